// File: rtl/ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | ctrl_pkg: state, opcode and datapath-select encodings shared by the   |
// | multicycle control FSM.                                               |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_IMM       = 4'd3,
    S_ALU_R     = 4'd4,
    S_ALU_RI    = 4'd5,
    S_ALU_WB    = 4'd6,
    S_BRANCH    = 4'd7,
    S_MEM_ADDR  = 4'd8,
    S_LOAD_MEM  = 4'd9,
    S_LOAD_WB   = 4'd10,
    S_STORE_MEM = 4'd11,
    S_JUMP      = 4'd12,
    S_HALT      = 4'd13,
    S_FAULT     = 4'd14
  } state_t;

  // ALU headers match only the top two opcode bits; the rest match three.
  localparam logic [1:0] ALU_R_HDR  = 2'b00;
  localparam logic [1:0] ALU_RI_HDR = 2'b01;
  localparam logic [2:0] BRANCH_HDR = 3'b100;
  localparam logic [2:0] MEMREF_HDR = 3'b101;
  localparam logic [2:0] JUMP_HDR   = 3'b110;
  localparam logic [5:0] LDI        = 6'b111000;
  localparam logic [5:0] HALT       = 6'b111111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OPC   = 2'b11;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_IMM    = 2'b10;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_LOAD_MEM) || (s == S_STORE_MEM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// +----------------------------------------------------------------------+
// | mem_wait_timer: counts consecutive not-ready cycles in a memory state |
// | and flags when the count reaches MAX_WAIT.                            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_wait_timer #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [WAIT_W-1:0] count;

  assign expired = (count == WAIT_W'(MAX_WAIT));

  // Holding at MAX_WAIT keeps the counter from wrapping if a state lingers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
// +----------------------------------------------------------------------+
// | multicycle_ctrl_fsm: fetch/decode/execute/memory/write-back sequencer |
// | with memory-ready handshake, wait timeout, HALT and FAULT states.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module multicycle_ctrl_fsm #(
  parameter int OPCODE_W = 6,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_i_or_d,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic [1:0]          pc_src,
  output logic [1:0]          reg_wdata_sel,
  output logic                instr_done,
  output logic                halted,
  output logic                fault,
  output logic [3:0]          state_o
);

  import ctrl_pkg::*;

  state_t     state;
  state_t     state_next;
  logic       expired;
  logic [2:0] hdr;
  logic [5:0] op_full;

  assign hdr     = opcode[OPCODE_W-1 -: 3];
  assign op_full = opcode[OPCODE_W-1 -: 6];
  assign state_o = state;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_next != state),
    .count_en (is_mem_state(state) && !mem_ready),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_i_or_d    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALU_ADD;
    pc_src        = PC_ALU;
    reg_wdata_sel = WD_ALUOUT;
    halted        = 1'b0;
    fault         = 1'b0;

    case (state)
      S_INIT: state_next = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_ONE;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    state_next = S_DECODE;
        else if (expired) state_next = S_FAULT;
      end
      S_DECODE: begin
        alu_src_b = SRCB_BROFF;
        if (hdr[2:1] == ALU_R_HDR)       state_next = S_ALU_R;
        else if (hdr[2:1] == ALU_RI_HDR) state_next = S_ALU_RI;
        else if (hdr == BRANCH_HDR)      state_next = S_BRANCH;
        else if (hdr == MEMREF_HDR)      state_next = S_MEM_ADDR;
        else if (hdr == JUMP_HDR)        state_next = S_JUMP;
        else if (op_full == LDI)         state_next = S_IMM;
        else if (op_full == HALT)        state_next = S_HALT;
        else                             state_next = S_FAULT;
      end
      S_IMM: begin
        reg_write     = 1'b1;
        reg_wdata_sel = WD_IMM;
        state_next    = S_FETCH;
      end
      S_ALU_R: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_B;
        alu_op     = ALU_FUNCT;
        state_next = S_ALU_WB;
      end
      S_ALU_RI: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALU_OPC;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write     = 1'b1;
        reg_wdata_sel = WD_ALUOUT;
        state_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_ALUOUT;
        state_next    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        state_next = opcode[2] ? S_STORE_MEM : S_LOAD_MEM;
      end
      S_LOAD_MEM: begin
        mem_read   = 1'b1;
        mem_i_or_d = 1'b1;
        if (mem_ready)    state_next = S_LOAD_WB;
        else if (expired) state_next = S_FAULT;
      end
      S_LOAD_WB: begin
        reg_write     = 1'b1;
        reg_wdata_sel = WD_MDR;
        state_next    = S_FETCH;
      end
      S_STORE_MEM: begin
        mem_write  = 1'b1;
        mem_i_or_d = 1'b1;
        if (mem_ready)    state_next = S_FETCH;
        else if (expired) state_next = S_FAULT;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PC_JUMP;
        state_next = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
      default: state_next = S_FAULT;
    endcase
  end

  // Retirement is any transition back into FETCH from an executing state.
  assign instr_done = (state_next == S_FETCH) && (state != S_INIT) && (state != S_FETCH);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
// +----------------------------------------------------------------------+
// | tb_multicycle_ctrl_fsm: directed self-checking bench for the control  |
// | FSM. Revision: 1.0                                                    |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
  logic       mem_i_or_d, alu_src_a, instr_done, halted, fault;
  logic [1:0] alu_src_b, alu_op, pc_src, reg_wdata_sel;
  logic [3:0] state_o;
  logic [18:0] all_outs;

  int n_cmp;
  int n_fail;

  multicycle_ctrl_fsm #(
    .OPCODE_W (6),
    .MAX_WAIT (15),
    .WAIT_W   (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_i_or_d    (mem_i_or_d),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .reg_wdata_sel (reg_wdata_sel),
    .instr_done    (instr_done),
    .halted        (halted),
    .fault         (fault),
    .state_o       (state_o)
  );

  assign all_outs = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
                     mem_i_or_d, alu_src_a, alu_src_b, alu_op, pc_src, reg_wdata_sel,
                     instr_done, halted, fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in INIT at a falling edge, with rst_n just released.
  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_alu_r();
    logic [3:0] exp_seq [0:4];
    int done_cnt;
    exp_seq  = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd1};
    done_cnt = 0;
    opcode   = 6'b000001;
    do_reset();
    n_cmp++;
    if (state_o !== 4'd0 || all_outs !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state: state %0d outs %h, expected state 0 outs 0", state_o, all_outs);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (state_o !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL alu_r_state[%0d]: got %0d expected %0d", i, state_o, exp_seq[i]);
      end
      n_cmp++;
      if (reg_write !== (exp_seq[i] == 4'd6)) begin
        n_fail++;
        $display("FAIL alu_r_reg_write[%0d]: got %b expected %b", i, reg_write, exp_seq[i] == 4'd6);
      end
      if (i == 1) begin
        n_cmp++;
        if (alu_src_b !== 2'b11) begin
          n_fail++;
          $display("FAIL decode_alu_src_b: got %b expected 11", alu_src_b);
        end
      end
      if (instr_done === 1'b1) done_cnt++;
    end
    n_cmp++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL alu_r_instr_done: got %0d pulses expected 1", done_cnt);
    end
  endtask

  task automatic test_load_wait();
    int waits, cycles, wb;
    waits = 0; cycles = 0; wb = 0;
    opcode = 6'b101000;
    do_reset();
    tick();
    for (int c = 0; c < 30; c++) begin
      if (state_o == 4'd9 && waits < 3) begin
        mem_ready = 1'b0;
        waits++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (reg_write === 1'b1 && reg_wdata_sel === 2'b01) wb++;
      tick();
      cycles++;
      if (state_o == 4'd1) break;
    end
    mem_ready = 1'b1;
    n_cmp++;
    if (cycles != 8) begin
      n_fail++;
      $display("FAIL load_cycles: got %0d expected 8", cycles);
    end
    n_cmp++;
    if (wb != 1) begin
      n_fail++;
      $display("FAIL load_wb_cycles: got %0d expected 1", wb);
    end
  endtask

  task automatic test_store_wait(input int nready, input logic [3:0] exp_after,
                                 input int exp_cycles, input string name);
    int sc, wc, mw, bound;
    sc = 0; wc = 0; mw = 0; bound = 0;
    opcode = 6'b101100;
    do_reset();
    while (state_o != 4'd11 && bound < 20) begin
      tick();
      bound++;
    end
    n_cmp++;
    if (state_o !== 4'd11) begin
      n_fail++;
      $display("FAIL %s_reach_store: state %0d expected 11", name, state_o);
    end
    while (state_o == 4'd11 && sc < 40) begin
      if (wc < nready) begin
        mem_ready = 1'b0;
        wc++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (mem_write === 1'b1) mw++;
      sc++;
      tick();
    end
    n_cmp++;
    if (sc != exp_cycles || mw != exp_cycles) begin
      n_fail++;
      $display("FAIL %s_store_cycles: got %0d (mem_write %0d) expected %0d", name, sc, mw, exp_cycles);
    end
    n_cmp++;
    if (state_o !== exp_after) begin
      n_fail++;
      $display("FAIL %s_next_state: got %0d expected %0d", name, state_o, exp_after);
    end
    if (exp_after == 4'd14) begin
      n_cmp++;
      if (fault !== 1'b1 || mem_write !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_fault_flags: fault %b mem_write %b expected 1 0", name, fault, mem_write);
      end
      mem_ready = 1'b1;
      repeat (5) tick();
      n_cmp++;
      if (state_o !== 4'd14 || fault !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_fault_sticky: state %0d fault %b expected 14 1", name, state_o, fault);
      end
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_undef_opcode();
    int fwait, irw, wr_bad, t;
    fwait = 0; irw = 0; wr_bad = 0; t = 0;
    opcode = 6'b111010;
    do_reset();
    tick();
    while (state_o != 4'd14 && t < 12) begin
      if (state_o == 4'd1 && fwait < 2) begin
        mem_ready = 1'b0;
        fwait++;
      end else begin
        mem_ready = 1'b1;
      end
      #1;
      if (ir_write === 1'b1 && pc_write === 1'b1) irw++;
      if (state_o != 4'd1 && (pc_write | pc_write_cond | ir_write | reg_write | mem_write) !== 1'b0)
        wr_bad++;
      tick();
      t++;
    end
    mem_ready = 1'b1;
    n_cmp++;
    if (t != 4 || state_o !== 4'd14) begin
      n_fail++;
      $display("FAIL undef_to_fault: state %0d after %0d cycles expected 14 after 4", state_o, t);
    end
    n_cmp++;
    if (irw != 1) begin
      n_fail++;
      $display("FAIL fetch_ir_write_cycles: got %0d expected 1", irw);
    end
    n_cmp++;
    if (wr_bad != 0 || (pc_write | pc_write_cond | ir_write | reg_write | mem_write) !== 1'b0) begin
      n_fail++;
      $display("FAIL undef_write_enables: got %0d bad cycles expected 0", wr_bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops  [0:2];
    logic [3:0] sts  [0:2];
    logic [8:0] sigs [0:2];
    ops  = '{6'b111000, 6'b110000, 6'b100000};
    sts  = '{4'd3, 4'd12, 4'd7};
    sigs = '{9'b001001000, 9'b100100000, 9'b010010001};
    opcode = 6'b000000;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      opcode = ops[k];
      tick();
      tick();
      n_cmp++;
      if (state_o !== sts[k] || instr_done !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_state[%0d]: state %0d done %b expected %0d 1", k, state_o, instr_done, sts[k]);
      end
      n_cmp++;
      if ({pc_write, pc_write_cond, reg_write, pc_src, reg_wdata_sel, alu_op} !== sigs[k]) begin
        n_fail++;
        $display("FAIL b2b_controls[%0d]: got %b expected %b", k,
                 {pc_write, pc_write_cond, reg_write, pc_src, reg_wdata_sel, alu_op}, sigs[k]);
      end
    end
    tick();
    n_cmp++;
    if (state_o !== 4'd1) begin
      n_fail++;
      $display("FAIL b2b_final_fetch: got %0d expected 1", state_o);
    end
  endtask

  task automatic test_halt();
    int hc;
    hc = 0;
    opcode = 6'b111111;
    do_reset();
    repeat (3) tick();
    n_cmp++;
    if (state_o !== 4'd13 || halted !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_enter: state %0d halted %b expected 13 1", state_o, halted);
    end
    repeat (50) begin
      tick();
      if (halted === 1'b1 && state_o == 4'd13) hc++;
    end
    n_cmp++;
    if (hc != 50) begin
      n_fail++;
      $display("FAIL halt_sticky: got %0d cycles expected 50", hc);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 4'd0 || all_outs !== 19'd0) begin
      n_fail++;
      $display("FAIL halt_reset: state %0d outs %h expected 0 0", state_o, all_outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (state_o !== 4'd1) begin
      n_fail++;
      $display("FAIL halt_refetch: got %0d expected 1", state_o);
    end
  endtask

  task automatic test_reset_in_load();
    int bound;
    bound = 0;
    opcode = 6'b101000;
    do_reset();
    while (state_o != 4'd9 && bound < 20) begin
      tick();
      bound++;
    end
    mem_ready = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 4'd9 || mem_read !== 1'b1 || mem_i_or_d !== 1'b1) begin
      n_fail++;
      $display("FAIL load_mem_strobes: state %0d read %b i_or_d %b expected 9 1 1", state_o, mem_read, mem_i_or_d);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (state_o !== 4'd0 || all_outs !== 19'd0) begin
      n_fail++;
      $display("FAIL async_reset: state %0d outs %h expected 0 0", state_o, all_outs);
    end
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'b000000;
    test_reset_alu_r();
    test_load_wait();
    test_store_wait(100, 4'd14, 16, "store_timeout");
    test_store_wait(15, 4'd1, 16, "store_ready_at_limit");
    test_undef_opcode();
    test_back_to_back();
    test_halt();
    test_reset_in_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
